// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns PC/LR, drives a req/gnt/rvalid instruction port and
// redirects on branch commands from decode, flushing wrong-path work.
module fetch_sequencer #(
  parameter logic [15:0] RESET_VEC    = 16'h0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_halt_req,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [15:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  input  logic        i_br_valid,
  output logic        o_br_ready,
  input  logic [2:0]  i_br_code,
  input  logic [15:0] i_br_pc,
  input  logic [7:0]  i_br_upper,
  input  logic [2:0]  i_br_lower,
  input  logic        i_br_carry,
  input  logic [15:0] i_br_abs,
  output logic        o_flush,
  output logic [15:0] o_lr,
  output logic        o_halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT, S_HOLD, S_DRAIN, S_FLUSH, S_HALT
  } seqState_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  seqState_t   r_state, w_nextState;
  logic [15:0] r_pc, r_lr, r_instr, r_instrPc;
  logic        r_instrValid;
  logic [2:0]  r_flushCnt, w_nextCnt, w_cntDec;
  logic [7:0]  w_pageHi;
  logic [15:0] w_target;
  logic        w_brReady, w_brAccept, w_wordIn;

  assign w_brReady  = !i_reset &&
                      (r_state == S_FETCH || r_state == S_WAIT || r_state == S_HOLD);
  assign w_brAccept = i_br_valid && w_brReady;
  assign w_wordIn   = (r_state == S_WAIT) && i_imem_rvalid && !w_brAccept;
  assign w_cntDec   = (r_flushCnt != 3'd0) ? r_flushCnt - 3'd1 : 3'd0;
  assign w_pageHi   = i_br_pc[15:8] + {5'b0, i_br_lower} + {7'b0, i_br_carry};

  // Return (11) reads the LR value held before any link write this cycle.
  always_comb begin
    w_target = i_br_pc + 16'd1;
    case (i_br_code[1:0])
      2'b00:   w_target = i_br_pc + 16'd1;
      2'b01:   w_target = {w_pageHi, i_br_upper};
      2'b10:   w_target = i_br_abs;
      default: w_target = r_lr;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_flushCnt;
    case (r_state)
      S_FETCH: begin
        if (w_brAccept) begin
          w_nextState = i_imem_gnt ? S_DRAIN : S_FLUSH;
          w_nextCnt   = FLUSH_LOAD;
        end else if (i_imem_gnt) begin
          w_nextState = S_WAIT;
        end else if (i_halt_req) begin
          w_nextState = S_HALT;
        end
      end
      S_WAIT: begin
        if (w_brAccept) begin
          w_nextState = i_imem_rvalid ? S_FLUSH : S_DRAIN;
          w_nextCnt   = FLUSH_LOAD;
        end else if (i_imem_rvalid) begin
          w_nextState = i_stall ? S_HOLD : S_FETCH;
        end
      end
      S_HOLD: begin
        if (w_brAccept) begin
          w_nextState = S_FLUSH;
          w_nextCnt   = FLUSH_LOAD;
        end else if (i_halt_req) begin
          w_nextState = S_HALT;
        end else if (!i_stall) begin
          w_nextState = S_FETCH;
        end
      end
      // Flush cycles keep elapsing while the orphaned word is outstanding.
      S_DRAIN: begin
        w_nextCnt = w_cntDec;
        if (i_imem_rvalid) begin
          w_nextState = (r_flushCnt <= 3'd1) ? S_FETCH : S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_nextCnt = w_cntDec;
        if (r_flushCnt <= 3'd1) begin
          w_nextState = S_FETCH;
        end
      end
      S_HALT:  w_nextState = S_HALT;
      default: w_nextState = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_FETCH;
      r_flushCnt   <= 3'd0;
      r_pc         <= RESET_VEC;
      r_lr         <= 16'h0000;
      r_instr      <= 16'h0000;
      r_instrPc    <= 16'h0000;
      r_instrValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_flushCnt <= w_nextCnt;
      if (w_brAccept && i_br_code[2]) begin
        r_lr <= i_br_pc + 16'd1;
      end
      if (w_brAccept) begin
        r_pc         <= w_target;
        r_instrValid <= 1'b0;
      end else if (w_wordIn) begin
        r_instr      <= i_imem_rdata;
        r_instrPc    <= r_pc;
        r_instrValid <= 1'b1;
        r_pc         <= r_pc + 16'd1;
      end else if (!i_stall) begin
        r_instrValid <= 1'b0;
      end
    end
  end

  assign o_imem_req    = !i_reset && (r_state == S_FETCH);
  assign o_imem_addr   = r_pc;
  assign o_br_ready    = w_brReady;
  assign o_flush       = !i_reset && (r_state == S_DRAIN || r_state == S_FLUSH);
  assign o_halted      = !i_reset && (r_state == S_HALT);
  assign o_instr_valid = r_instrValid;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instrPc;
  assign o_lr          = r_lr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch sequencing, branch targets/link,
// drain/flush on redirect, stall hold, halt and reset recovery.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset, stall, haltReq;
  logic        imemReq, imemGnt, imemRvalid;
  logic [15:0] imemAddr, imemRdata;
  logic        instrValid;
  logic [15:0] instr, instrPc;
  logic        brValid, brReady;
  logic [2:0]  brCode;
  logic [15:0] brPc, brAbs;
  logic [7:0]  brUpper;
  logic [2:0]  brLower;
  logic        brCarry;
  logic        flush, halted;
  logic [15:0] lr;

  int checkCount = 0;
  int failCount  = 0;

  fetch_sequencer #(.RESET_VEC(16'h0000), .FLUSH_CYCLES(1)) dut (
    .i_clk(clock), .i_reset(reset), .i_stall(stall), .i_halt_req(haltReq),
    .o_imem_req(imemReq), .o_imem_addr(imemAddr), .i_imem_gnt(imemGnt),
    .i_imem_rvalid(imemRvalid), .i_imem_rdata(imemRdata),
    .o_instr_valid(instrValid), .o_instr(instr), .o_instr_pc(instrPc),
    .i_br_valid(brValid), .o_br_ready(brReady), .i_br_code(brCode),
    .i_br_pc(brPc), .i_br_upper(brUpper), .i_br_lower(brLower),
    .i_br_carry(brCarry), .i_br_abs(brAbs), .o_flush(flush), .o_lr(lr),
    .o_halted(halted)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic gnt, input logic rvalid,
                               input logic [15:0] rdata, input logic stallIn);
    imemGnt    = gnt;
    imemRvalid = rvalid;
    imemRdata  = rdata;
    stall      = stallIn;
  endtask

  // One full fetch from FETCH: grant, then data on the following cycle.
  task automatic fetchWord(input logic [15:0] word, input logic stallAtData);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("waitNoReq", imemReq, 0);
    applyStimulus(1'b0, 1'b1, word, stallAtData);
    tick();
    imemRvalid = 1'b0;
  endtask

  task automatic doBranch(input logic [2:0] code, input logic [15:0] pc,
                          input logic [7:0] upper, input logic [2:0] lower,
                          input logic carry, input logic [15:0] abs);
    brCode  = code;
    brPc    = pc;
    brUpper = upper;
    brLower = lower;
    brCarry = carry;
    brAbs   = abs;
    brValid = 1'b1;
    tick();
    brValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; haltReq = 1'b0; brValid = 1'b0;
    brCode = 3'b000; brPc = 16'h0; brAbs = 16'h0;
    brUpper = 8'h0; brLower = 3'h0; brCarry = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    tick();
    checkOutput("rstReq", imemReq, 0);
    checkOutput("rstAddr", imemAddr, 16'h0000);
    checkOutput("rstBrReady", brReady, 0);
    checkOutput("rstValid", instrValid, 0);
    checkOutput("rstLr", lr, 16'h0000);
    checkOutput("rstFlush", flush, 0);
    checkOutput("rstHalted", halted, 0);
    reset = 1'b0;
    #1;
    checkOutput("fetchReq", imemReq, 1);
    checkOutput("fetchBrReady", brReady, 1);

    fetchWord(16'hA000, 1'b0);
    checkOutput("f0Valid", instrValid, 1);
    checkOutput("f0Instr", instr, 16'hA000);
    checkOutput("f0Pc", instrPc, 16'h0000);
    checkOutput("f0Addr", imemAddr, 16'h0001);
    fetchWord(16'hA001, 1'b0);
    checkOutput("f1Pc", instrPc, 16'h0001);
    checkOutput("f1Addr", imemAddr, 16'h0002);
    checkOutput("f1Lr", lr, 16'h0000);

    // Page-relative with link: 0x12+3+1 = 0x16, low byte 0x34.
    doBranch(3'b101, 16'h12F0, 8'h34, 3'd3, 1'b1, 16'h0000);
    checkOutput("pageAddr", imemAddr, 16'h1634);
    checkOutput("pageLr", lr, 16'h12F1);
    checkOutput("pageFlush", flush, 1);
    checkOutput("pageValid", instrValid, 0);
    checkOutput("pageBrReady", brReady, 0);
    checkOutput("pageReq", imemReq, 0);
    tick();
    checkOutput("pageFlushEnd", flush, 0);
    checkOutput("pageReqBack", imemReq, 1);

    doBranch(3'b110, 16'h01FF, 8'h00, 3'd0, 1'b0, 16'h3000);
    tick();
    checkOutput("absAddr", imemAddr, 16'h3000);
    checkOutput("absLr", lr, 16'h0200);

    doBranch(3'b011, 16'h9999, 8'h00, 3'd0, 1'b0, 16'h0000);
    checkOutput("retAddr", imemAddr, 16'h0200);
    checkOutput("retLr", lr, 16'h0200);
    tick();
    fetchWord(16'hB000, 1'b0);
    checkOutput("retFetchPc", instrPc, 16'h0200);
    checkOutput("retFetchAddr", imemAddr, 16'h0201);

    doBranch(3'b111, 16'h4444, 8'h00, 3'd0, 1'b0, 16'h0000);
    checkOutput("retLinkAddr", imemAddr, 16'h0200);
    checkOutput("retLinkLr", lr, 16'h4445);
    tick();

    doBranch(3'b001, 16'hFF00, 8'h55, 3'd7, 1'b1, 16'h0000);
    checkOutput("pageWrapAddr", imemAddr, 16'h0755);
    checkOutput("pageWrapLr", lr, 16'h4445);
    tick();

    doBranch(3'b000, 16'h0ABC, 8'h00, 3'd0, 1'b0, 16'h0000);
    checkOutput("seqAddr", imemAddr, 16'h0ABD);
    tick();

    doBranch(3'b010, 16'h0000, 8'h00, 3'd0, 1'b0, 16'hFFFF);
    tick();
    fetchWord(16'hC000, 1'b0);
    checkOutput("wrapPc", instrPc, 16'hFFFF);
    checkOutput("wrapAddr", imemAddr, 16'h0000);

    // Redirect while a granted word is still outstanding.
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    tick();
    imemGnt = 1'b0;
    doBranch(3'b010, 16'h0000, 8'h00, 3'd0, 1'b0, 16'h5000);
    checkOutput("drainFlush", flush, 1);
    checkOutput("drainReq", imemReq, 0);
    checkOutput("drainBrReady", brReady, 0);
    checkOutput("drainAddr", imemAddr, 16'h5000);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("drainHold", flush, 1);
    end
    applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0);
    tick();
    imemRvalid = 1'b0;
    checkOutput("drainDropValid", instrValid, 0);
    checkOutput("drainDropInstr", instr, 16'hC000);
    checkOutput("drainDone", flush, 0);
    checkOutput("drainReqBack", imemReq, 1);
    fetchWord(16'hD000, 1'b0);
    checkOutput("drainTgtPc", instrPc, 16'h5000);
    checkOutput("drainTgtInstr", instr, 16'hD000);

    // Branch and data in the same WAIT cycle: branch wins.
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 16'hEEEE, 1'b0);
    doBranch(3'b010, 16'h0000, 8'h00, 3'd0, 1'b0, 16'h6000);
    imemRvalid = 1'b0;
    checkOutput("raceValid", instrValid, 0);
    checkOutput("raceInstr", instr, 16'hD000);
    checkOutput("raceFlush", flush, 1);
    checkOutput("raceAddr", imemAddr, 16'h6000);
    tick();
    checkOutput("raceFlushEnd", flush, 0);

    // Branch in FETCH together with a grant: that grant must be drained.
    imemGnt = 1'b1;
    doBranch(3'b010, 16'h0000, 8'h00, 3'd0, 1'b0, 16'h7000);
    imemGnt = 1'b0;
    checkOutput("gntDrainFlush", flush, 1);
    tick();
    checkOutput("gntDrainHold", flush, 1);
    applyStimulus(1'b0, 1'b1, 16'h3333, 1'b0);
    tick();
    imemRvalid = 1'b0;
    checkOutput("gntDrainDone", flush, 0);
    checkOutput("gntDrainAddr", imemAddr, 16'h7000);
    checkOutput("gntDrainValid", instrValid, 0);

    // Stall at data arrival; a stray rvalid in HOLD must be ignored.
    fetchWord(16'hBEEF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("holdValid", instrValid, 1);
      checkOutput("holdInstr", instr, 16'hBEEF);
      checkOutput("holdPc", instrPc, 16'h7000);
      checkOutput("holdReq", imemReq, 0);
      if (i == 1) applyStimulus(1'b0, 1'b1, 16'h1111, 1'b1);
      tick();
      imemRvalid = 1'b0;
    end
    checkOutput("holdStray", instr, 16'hBEEF);
    stall = 1'b0;
    tick();
    checkOutput("releaseValid", instrValid, 0);
    checkOutput("releaseReq", imemReq, 1);
    checkOutput("releaseAddr", imemAddr, 16'h7001);

    // Halt requested while a fetch is in flight.
    haltReq = 1'b1;
    fetchWord(16'hF00D, 1'b0);
    checkOutput("haltPending", halted, 0);
    checkOutput("haltDonePc", instrPc, 16'h7001);
    checkOutput("haltDoneInstr", instr, 16'hF00D);
    tick();
    checkOutput("halted", halted, 1);
    checkOutput("haltReq", imemReq, 0);
    checkOutput("haltBrReady", brReady, 0);
    doBranch(3'b110, 16'h0000, 8'h00, 3'd0, 1'b0, 16'h1234);
    checkOutput("haltNoBranch", imemAddr, 16'h7002);
    checkOutput("haltNoLink", lr, 16'h4445);
    haltReq = 1'b0;

    // Reset out of HALT, then reset mid-transaction with a late rvalid.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reHalted", halted, 0);
    checkOutput("reAddr", imemAddr, 16'h0000);
    checkOutput("reLr", lr, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    tick();
    imemGnt = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h2222, 1'b0);
    tick();
    imemRvalid = 1'b0;
    checkOutput("lateValid", instrValid, 0);
    checkOutput("lateAddr", imemAddr, 16'h0000);
    checkOutput("lateReq", imemReq, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
